circ_shift_sched: RTL and testbench

Sequencing controller for the barrel-style `circular_shift` datapath in the non-power-of-two NTT. It accepts a job consisting of a SIZE-element vector, a base rotation, a stride and a count. It then emits `count` rotated copies of that vector with rotation amounts `base + k*stride mod SIZE`, for k = 0..count-1, over a valid/ready stream. It sits between the NTT stage controller (job issue) and the twiddle/butterfly lanes (consumers).

---
 rtl/circ_shift_pkg.sv | 34 +++
 rtl/circular_shift.sv | 33 +++
 rtl/circ_shift_sched.sv | 130 +++++++++++++
 tb/tb_circ_shift_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/circ_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : circ_shift_pkg
// Desc     : Shared constants, FSM state type and mod-SIZE helpers.
// Revision : 1.0
// ============================================================================
package circ_shift_pkg;

  localparam int SIZE  = 257;
  localparam int WIDTH = 32;
  localparam int SHW   = 9;

  localparam logic [SHW:0] c_size_ext = (SHW+1)'(SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Valid only for x < 2*SIZE, which SHW guarantees for every caller.
  function automatic logic [SHW-1:0] mod_size_red(input logic [SHW:0] x);
    logic [SHW:0] t;
    t = (x >= c_size_ext) ? (x - c_size_ext) : x;
    return t[SHW-1:0];
  endfunction

  function automatic logic [SHW-1:0] mod_size_add(input logic [SHW-1:0] a,
                                                  input logic [SHW-1:0] b);
    return mod_size_red({1'b0, a} + {1'b0, b});
  endfunction

endpackage
`default_nettype wire

// File: rtl/circular_shift.sv
`default_nettype none
// ============================================================================
// Module   : circular_shift
// Desc     : Combinational rotation, list_o[i] = list_i[(i + shift_i) mod SIZE].
// Revision : 1.0
// ============================================================================
module circular_shift #(
  parameter int SIZE  = 257,
  parameter int WIDTH = 32,
  parameter int SHW   = 9
) (
  input  logic [SIZE-1:0][WIDTH-1:0] list_i,
  input  logic [SHW-1:0]             shift_i,
  output logic [SIZE-1:0][WIDTH-1:0] list_o
);

  logic [WIDTH-1:0] stage [SHW+1][SIZE];

  for (genvar i = 0; i < SIZE; i++) begin : g_in
    assign stage[0][i] = list_i[i];
    assign list_o[i]   = stage[SHW][i];
  end

  // Stage k rotates by 2^k mod SIZE; rotations compose additively mod SIZE.
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    for (genvar i = 0; i < SIZE; i++) begin : g_elem
      localparam int SRC = (i + ((1 << k) % SIZE)) % SIZE;
      assign stage[k+1][i] = shift_i[k] ? stage[k][SRC] : stage[k][i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/circ_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : circ_shift_sched
// Desc     : Emits count rotated copies of a vector, shift = base + k*stride mod SIZE.
// Options  : CIRC_SHIFT_SCHED_ABORT_EN adds a synchronous abort_i input.
// Revision : 1.0
// ============================================================================
module circ_shift_sched
  import circ_shift_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef CIRC_SHIFT_SCHED_ABORT_EN
  input  logic                        abort_i,
`endif
  input  logic                        cfg_valid_i,
  output logic                        cfg_ready_o,
  input  logic [SIZE-1:0][WIDTH-1:0]  cfg_list_i,
  input  logic [SHW-1:0]              cfg_base_i,
  input  logic [SHW-1:0]              cfg_stride_i,
  input  logic [SHW-1:0]              cfg_count_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [SIZE-1:0][WIDTH-1:0]  out_list_o,
  output logic [SHW-1:0]              out_shift_o,
  output logic                        out_last_o,
  output logic                        busy_o,
  output logic                        done_o
);

  sched_state_t state_q, state_d;

  logic [SIZE-1:0][WIDTH-1:0] vec_q;
  logic [SIZE-1:0][WIDTH-1:0] shifted;
  logic [SHW-1:0]             amt_q, stride_q, rem_q;
  logic                       out_valid_q, out_last_q, done_q, done_d;
  logic [SIZE-1:0][WIDTH-1:0] out_list_q;
  logic [SHW-1:0]             out_shift_q;

  logic accept, load, hs, kill, abort_w;

`ifdef CIRC_SHIFT_SCHED_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  circular_shift #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .list_i  (vec_q),
    .shift_i (amt_q),
    .list_o  (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (cfg_count_i != '0)) state_d = RUN;
      RUN:     if (load && (rem_q == SHW'(1)))   state_d = DRAIN;
      DRAIN:   if (hs)                            state_d = IDLE;
      default:                                    state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Abort outranks both a pending reload and the final handshake.
  always_comb begin
    cfg_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    accept      = (state_q == IDLE) && cfg_valid_i;
    hs          = out_valid_q && out_ready_i;
    kill        = abort_w && (state_q != IDLE);
    load        = (state_q == RUN) && (!out_valid_q || out_ready_i) && !kill;
    done_d      = !kill && ((accept && (cfg_count_i == '0)) ||
                            ((state_q == DRAIN) && hs));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= '0;
      amt_q       <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_list_q  <= '0;
      out_shift_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        vec_q    <= cfg_list_i;
        amt_q    <= mod_size_red({1'b0, cfg_base_i});
        stride_q <= mod_size_red({1'b0, cfg_stride_i});
        rem_q    <= cfg_count_i;
      end else if (load) begin
        amt_q <= mod_size_add(amt_q, stride_q);
        rem_q <= rem_q - SHW'(1);
      end
      if (kill) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
        out_list_q  <= shifted;
        out_shift_q <= amt_q;
        out_last_q  <= (rem_q == SHW'(1));
      end else if (hs) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_list_o  = out_list_q;
  assign out_shift_o = out_shift_q;
  assign out_last_o  = out_last_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_circ_shift_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_circ_shift_sched
// Desc     : Scoreboard bench for circ_shift_sched (CIRC_SHIFT_SCHED_ABORT_EN aware).
// Revision : 1.0
// ============================================================================
module tb_circ_shift_sched;
  import circ_shift_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n;
  logic                       cfg_valid, cfg_ready;
  logic [SIZE-1:0][WIDTH-1:0] cfg_list;
  logic [SHW-1:0]             cfg_base, cfg_stride, cfg_count;
  logic                       out_valid, out_ready;
  logic [SIZE-1:0][WIDTH-1:0] out_list;
  logic [SHW-1:0]             out_shift;
  logic                       out_last, busy, done;
`ifdef CIRC_SHIFT_SCHED_ABORT_EN
  logic                       abort;
`endif

  circ_shift_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef CIRC_SHIFT_SCHED_ABORT_EN
    .abort_i      (abort),
`endif
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_list_i   (cfg_list),
    .cfg_base_i   (cfg_base),
    .cfg_stride_i (cfg_stride),
    .cfg_count_i  (cfg_count),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_list_o   (out_list),
    .out_shift_o  (out_shift),
    .out_last_o   (out_last),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct {
    int                         shift;
    bit                         last;
    logic [SIZE-1:0][WIDTH-1:0] list;
  } beat_t;

  beat_t exp_q[$];
  bit    model_busy = 0;
  bit    done_exp   = 0;
  int    gap        = 0;
  int    beats_seen = 0;
  int    checks     = 0;
  int    passes     = 0;
  int    hold_low   = 0;
  bit    rand_ready = 0;

  task automatic chk(input bit ok, input string nm, input longint got, input longint want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
  endtask

  // Reference: k-th beat rotates by (base + k*stride) mod SIZE, element i taken from (i+shift) mod SIZE.
  task automatic push_job(input int base, input int stride, input int count,
                          input logic [SIZE-1:0][WIDTH-1:0] list);
    beat_t b;
    for (int k = 0; k < count; k++) begin
      b.shift = (base + k * stride) % SIZE;
      b.last  = (k == count - 1);
      for (int i = 0; i < SIZE; i++) b.list[i] = list[(i + b.shift) % SIZE];
      exp_q.push_back(b);
    end
  endtask

  // Monitor / scoreboard: decides at each negedge what the following posedge must do.
  initial begin
    forever begin
      bit done_nx, busy_nx;
      int bad, bi;
      @(negedge clk);
      if (!rst_n) begin
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(out_last == 1'b0 && done == 1'b0 && busy == 1'b0, "rst_flags",
            {out_last, done, busy}, 0);
        chk(cfg_ready == 1'b1, "rst_cfg_ready", cfg_ready, 1);
        chk(out_shift == '0 && out_list == '0, "rst_out_data", out_shift, 0);
        exp_q.delete();
        model_busy = 0;
        done_exp   = 0;
        gap        = 0;
      end else begin
        done_nx = 0;
        busy_nx = model_busy;
        chk(cfg_ready == !model_busy, "cfg_ready", cfg_ready, !model_busy);
        chk(busy == model_busy, "busy", busy, model_busy);
        chk(done == done_exp, "done", done, done_exp);
        if (out_valid) begin
          gap = 0;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", out_shift, -1);
          end else begin
            chk(out_shift == SHW'(exp_q[0].shift), "out_shift", out_shift, exp_q[0].shift);
            chk(out_last == exp_q[0].last, "out_last", out_last, exp_q[0].last);
            bad = -1;
            for (int i = 0; i < SIZE; i++)
              if (bad < 0 && out_list[i] !== exp_q[0].list[i]) bad = i;
            bi = (bad < 0) ? 0 : bad;
            chk(bad < 0, "out_list_elem", out_list[bi], exp_q[0].list[bi]);
            if (out_ready) begin
              if (exp_q[0].last) begin
                done_nx = 1;
                busy_nx = 0;
              end
              void'(exp_q.pop_front());
              beats_seen++;
            end
          end
        end else if (exp_q.size() != 0) begin
          gap++;
          chk(gap <= 1, "beat_latency", gap, 1);
        end
`ifdef CIRC_SHIFT_SCHED_ABORT_EN
        if (abort && model_busy) begin
          exp_q.delete();
          done_nx = 0;
          busy_nx = 0;
        end
`endif
        if (cfg_valid && !model_busy) begin
          push_job(int'(cfg_base), int'(cfg_stride), int'(cfg_count), cfg_list);
          if (cfg_count == '0) done_nx = 1;
          else                 busy_nx = 1;
        end
        model_busy = busy_nx;
        done_exp   = done_nx;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_low > 0) begin
        out_ready = 1'b0;
        hold_low--;
      end else if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1'b1;
    end
  end

  task automatic issue(input int base, input int stride, input int count,
                       input logic [SIZE-1:0][WIDTH-1:0] list, input bit keep);
    int n;
    cfg_base   = SHW'(base);
    cfg_stride = SHW'(stride);
    cfg_count  = SHW'(count);
    cfg_list   = list;
    cfg_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) chk(1'b0, "cfg_accept_timeout", n, 3000);
    @(posedge clk);
    #1;
    if (!keep) cfg_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((model_busy || exp_q.size() != 0 || done_exp) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) chk(1'b0, "drain_timeout", n, 5000);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_seen < target && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk(1'b0, "beat_wait_timeout", beats_seen, target);
  endtask

  initial begin
    logic [SIZE-1:0][WIDTH-1:0] lst;
    int start;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_base  = '0;
    cfg_stride = '0;
    cfg_count = '0;
    cfg_list  = '0;
`ifdef CIRC_SHIFT_SCHED_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < SIZE; i++) lst[i] = WIDTH'(i);
    issue(300, 200, 3, lst, 0);
    wait_drain();

    for (int i = 0; i < SIZE; i++) lst[i] = $urandom;
    issue(5, 0, 4, lst, 0);
    hold_low = 6;
    wait_drain();

    issue(17, 3, 0, lst, 0);
    wait_drain();

    issue(10, 7, 3, lst, 1);
    issue(400, 11, 2, lst, 0);
    wait_drain();

    issue(256, 256, 3, lst, 0);
    wait_drain();

    start = beats_seen;
    issue(0, 1, 10, lst, 0);
    wait_beats(start + 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "async_reset_out_valid", out_valid, 0);
    chk(busy == 1'b0 && cfg_ready == 1'b1, "async_reset_idle", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < SIZE; i++) lst[i] = WIDTH'(i * 3 + 1);
    issue(1, 1, 2, lst, 0);
    wait_drain();

`ifdef CIRC_SHIFT_SCHED_ABORT_EN
    start = beats_seen;
    issue(9, 4, 10, lst, 0);
    wait_beats(start + 2);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    #1;
    chk(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
    wait_drain();
    abort = 1'b1;
    issue(20, 30, 2, lst, 0);
    abort = 1'b0;
    wait_drain();
`endif

    rand_ready = 1;
    for (int j = 0; j < 25; j++) begin
      for (int i = 0; i < SIZE; i++) lst[i] = $urandom;
      issue($urandom_range(0, 511), $urandom_range(0, 511),
            (j % 8 == 7) ? 20 : $urandom_range(0, 6), lst, 0);
    end
    wait_drain();
    rand_ready = 0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
